// File: rtl/sine_pwm_gen.sv
// sine_pwm_gen: multi-channel sine-weighted PWM generator.
// A shared PWM counter defines the PWM period. At every counter wrap each
// channel latches a new sine sample from its phase accumulator (quarter-wave
// table lookup), scales it to a duty value and then advances its phase.
// Optional feature: define SINE_PWM_COMP_EN to add complementary outputs
// pwm_n with a DEADTIME-clock dead band around every transition.
module sine_pwm_gen #(
    parameter int CH         = 2,
    parameter int PWM_W      = 8,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 6
`ifdef SINE_PWM_COMP_EN
    ,
    parameter int DEADTIME   = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PWM_W-1:0]      period,
    input  logic [CH*PHASE_W-1:0] ftw,
    output logic [CH-1:0]         pwm,
`ifdef SINE_PWM_COMP_EN
    output logic [CH-1:0]         pwm_n,
`endif
    output logic [CH*PWM_W-1:0]   sample,
    output logic                  cycle_start
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
    localparam logic [PWM_W-1:0] MID    = PWM_W'(1 << (PWM_W - 1));
    localparam logic [PWM_W-1:0] MID_M1 = PWM_W'((1 << (PWM_W - 1)) - 1);

    // Fixed-point format used only while elaborating the sine table.
    localparam int     FX_FRAC    = 28;
    localparam longint HALF_PI_FX = 64'd421657428;

    // Elaboration-time quarter-wave entry: round(A * sin(pi/2 * (i+0.5) / N))
    // with A = 2^(PWM_W-1)-1, evaluated by a Taylor series in fixed point so
    // no real arithmetic reaches the hardware.
    function automatic logic [PWM_W-1:0] quarter_sine(input int i);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint amp;
        x    = (HALF_PI_FX * longint'(2 * i + 1)) >>> (LUT_ADDR_W + 1);
        x2   = (x * x) >>> FX_FRAC;
        term = x;
        acc  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> FX_FRAC) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        amp = longint'((1 << (PWM_W - 1)) - 1);
        return PWM_W'((amp * acc + (longint'(1) <<< (FX_FRAC - 1))) >>> FX_FRAC);
    endfunction

    logic [PWM_W-1:0] lut [LUT_DEPTH];

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
        localparam logic [PWM_W-1:0] Q = quarter_sine(i);
        assign lut[i] = Q;
    end

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] period_sh;
    logic [PWM_W:0]   period_plus1;
    logic             wrap;

    assign wrap         = en & (cnt == period_sh);
    assign period_plus1 = {1'b0, period_sh} + 1'b1;

    // Shared PWM counter; the period is only picked up at a wrap so a new
    // value never truncates or stretches the period already in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            period_sh <= '0;
        end else if (en) begin
            if (wrap) begin
                cnt       <= '0;
                period_sh <= period;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // One-clock marker for the first clock of every PWM period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= wrap;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [PHASE_W-1:0]    phase;
        logic [PWM_W-1:0]      duty;
        logic [PWM_W-1:0]      sample_q;
        logic                  pwm_q;
        logic [1:0]            quad;
        logic [LUT_ADDR_W-1:0] idx;
        logic [LUT_ADDR_W-1:0] addr;
        logic [PWM_W-1:0]      q;
        logic [PWM_W-1:0]      new_sample;
        logic [2*PWM_W:0]      product;
        logic [PWM_W-1:0]      new_duty;
        logic                  below;
        logic                  unused_bits;

        // Quadrants 1 and 3 walk the quarter table backwards; quadrants
        // 2 and 3 reflect the value below mid, so the output stays in range.
        assign quad       = phase[PHASE_W-1 -: 2];
        assign idx        = phase[PHASE_W-3 -: LUT_ADDR_W];
        assign addr       = quad[0] ? ~idx : idx;
        assign q          = lut[addr];
        assign new_sample = quad[1] ? (MID_M1 - q) : (MID + q);

        // Duty scales the sample onto the period that is ending, which also
        // makes the first period after reset (period_sh = 0) a zero duty.
        assign product     = {{(PWM_W+1){1'b0}}, new_sample} * {{PWM_W{1'b0}}, period_plus1};
        assign new_duty    = product[2*PWM_W-1:PWM_W];
        assign unused_bits = ^{product[PWM_W-1:0], product[2*PWM_W]};
        assign below       = en & (cnt < duty);

        // Per-channel phase accumulator with sample and duty latched at a wrap.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase    <= '0;
                duty     <= '0;
                sample_q <= '0;
            end else if (wrap) begin
                sample_q <= new_sample;
                duty     <= new_duty;
                phase    <= phase + ftw[c*PHASE_W +: PHASE_W];
            end
        end

        assign sample[c*PWM_W +: PWM_W] = sample_q;
        assign pwm[c]                   = pwm_q;

`ifdef SINE_PWM_COMP_EN
        logic                below_n;
        logic [DEADTIME-1:0] hist_p;
        logic [DEADTIME-1:0] hist_n;
        logic                pwm_n_q;

        assign below_n  = en & ~(cnt < duty);
        assign pwm_n[c] = pwm_n_q;

        // Each side only turns on once its request has been stable for
        // DEADTIME+1 samples, while either side turns off immediately;
        // this guarantees a DEADTIME-clock gap and no overlap.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hist_p  <= '0;
                hist_n  <= '0;
                pwm_q   <= 1'b0;
                pwm_n_q <= 1'b0;
            end else begin
                hist_p  <= DEADTIME'({hist_p, below});
                hist_n  <= DEADTIME'({hist_n, below_n});
                pwm_q   <= below & (&hist_p);
                pwm_n_q <= below_n & (&hist_n);
            end
        end
`else
        // Registered compare; lags the counter by one clock.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= below;
            end
        end
`endif
    end

endmodule

// File: tb/tb_sine_pwm_gen.sv
// tb_sine_pwm_gen: randomized self-checking bench for sine_pwm_gen with a
// cycle-level behavioural reference model built from real-valued sine math.
`timescale 1ns/1ps
module tb_sine_pwm_gen;

    localparam int CH         = 2;
    localparam int PWM_W      = 8;
    localparam int PHASE_W    = 16;
    localparam int LUT_ADDR_W = 6;
`ifdef SINE_PWM_COMP_EN
    localparam int DT    = 2;
    localparam int OUT_W = 2 * CH + 1 + CH * PWM_W;
`else
    localparam int DT    = 0;
    localparam int OUT_W = CH + 1 + CH * PWM_W;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic [PWM_W-1:0]      period;
    logic [CH*PHASE_W-1:0] ftw;
    logic [CH-1:0]         pwm;
    logic [CH*PWM_W-1:0]   sample;
    logic                  cycle_start;
    logic [OUT_W-1:0]      dut_out;
`ifdef SINE_PWM_COMP_EN
    logic [CH-1:0]         pwm_n;
`endif

    int checks   = 0;
    int failures = 0;

    sine_pwm_gen #(
        .CH(CH), .PWM_W(PWM_W), .PHASE_W(PHASE_W), .LUT_ADDR_W(LUT_ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .period(period),
        .ftw(ftw),
        .pwm(pwm),
`ifdef SINE_PWM_COMP_EN
        .pwm_n(pwm_n),
`endif
        .sample(sample),
        .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

`ifdef SINE_PWM_COMP_EN
    assign dut_out = {pwm_n, pwm, cycle_start, sample};
`else
    assign dut_out = {pwm, cycle_start, sample};
`endif

    // Reference model state: counter, shadow period, per-channel phase,
    // duty, sample and run lengths of the raw compare high/low.
    int m_cnt;
    int m_psh;
    int m_phase  [CH];
    int m_duty   [CH];
    int m_sample [CH];
    int m_run_hi [CH];
    int m_run_lo [CH];
    bit m_cs;

    function automatic int sine_sample(input int ph);
        int  quad;
        int  idx;
        int  q;
        real ang;
        quad = ph >> (PHASE_W - 2);
        idx  = (ph >> (PHASE_W - 2 - LUT_ADDR_W)) % (1 << LUT_ADDR_W);
        if (quad % 2 == 1) idx = (1 << LUT_ADDR_W) - 1 - idx;
        ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(1 << LUT_ADDR_W);
        q   = $rtoi(real'((1 << (PWM_W - 1)) - 1) * $sin(ang) + 0.5);
        if (quad < 2) return (1 << (PWM_W - 1)) + q;
        return (1 << (PWM_W - 1)) - 1 - q;
    endfunction

    function automatic logic [OUT_W-1:0] model_vec();
        logic [CH-1:0]       p;
        logic [CH*PWM_W-1:0] s;
`ifdef SINE_PWM_COMP_EN
        logic [CH-1:0]       pn;
`endif
        for (int c = 0; c < CH; c++) begin
            p[c] = (m_run_hi[c] > DT);
            s[c*PWM_W +: PWM_W] = PWM_W'(m_sample[c]);
`ifdef SINE_PWM_COMP_EN
            pn[c] = (m_run_lo[c] > DT);
`endif
        end
`ifdef SINE_PWM_COMP_EN
        return {pn, p, m_cs, s};
`else
        return {p, m_cs, s};
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_psh = 0;
        m_cs  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_phase[c]  = 0;
            m_duty[c]   = 0;
            m_sample[c] = 0;
            m_run_hi[c] = 0;
            m_run_lo[c] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_step();
        bit wr;
        bit lt;
        int s;
        if (en) begin
            wr = (m_cnt == m_psh);
            for (int c = 0; c < CH; c++) begin
                lt = (m_cnt < m_duty[c]);
                m_run_hi[c] = lt ? m_run_hi[c] + 1 : 0;
                m_run_lo[c] = lt ? 0 : m_run_lo[c] + 1;
            end
            if (wr) begin
                for (int c = 0; c < CH; c++) begin
                    s = sine_sample(m_phase[c]);
                    m_duty[c]   = (s * (m_psh + 1)) >> PWM_W;
                    m_sample[c] = s;
                    m_phase[c]  = (m_phase[c] + int'(ftw[c*PHASE_W +: PHASE_W])) % (1 << PHASE_W);
                end
                m_psh = int'(period);
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_cs = wr;
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_run_hi[c] = 0;
                m_run_lo[c] = 0;
            end
            m_cs = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
    endtask

    // Reset must clear the outputs immediately and hold them across edges.
    task automatic test_reset();
        reset = 1'b0;
        en = 1'b0;
        period = '0;
        ftw = '0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (dut_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_immediate got=%h want=0", dut_out);
        end
        en = 1'b1;
        period = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_held got=%h want=0", dut_out);
        end
        #2 reset = 1'b0;
        model_reset();
    endtask

    // Constant phase on channel 0: sample 130, duty 130 of 256 from period 2.
    task automatic test_fixed_duty();
        int hi [5];
        int n_cs;
        hi = '{default: 0};
        n_cs = 0;
        period = 8'd255;
        ftw = {16'($urandom), 16'h0000};
        en = 1'b1;
        do_reset();
        repeat (3 * 256 + 4) begin
            tick();
            checks++;
            if (dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL fixed_duty t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
            if (cycle_start === 1'b1) n_cs++;
            if (n_cs < 5 && pwm[0] === 1'b1) hi[n_cs]++;
        end
        checks++;
        if (hi[1] != 0) begin
            failures++;
            $display("[TB] FAIL fixed_first_period_high got=%0d want=0", hi[1]);
        end
        checks++;
        if (hi[2] != 130 || hi[3] != 130) begin
            failures++;
            $display("[TB] FAIL fixed_high_count got=%0d,%0d want=130", hi[2], hi[3]);
        end
        checks++;
        if (sample[7:0] !== 8'd130) begin
            failures++;
            $display("[TB] FAIL fixed_sample got=%0d want=130", sample[7:0]);
        end
    endtask

    // ftw 0x0400 gives a 64-period sine; check peak, trough and symmetry.
    task automatic test_sine_sweep();
        int got [$];
        int budget;
        budget = 0;
        period = 8'd3;
        ftw = {16'($urandom), 16'h0400};
        en = 1'b1;
        do_reset();
        while (got.size() < 64 && budget < 400) begin
            tick();
            budget++;
            checks++;
            if (dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL sweep t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
            if (cycle_start === 1'b1) got.push_back(int'(sample[7:0]));
        end
        checks++;
        if (got.size() != 64) begin
            failures++;
            $display("[TB] FAIL sweep_timeout got=%0d samples want=64", got.size());
        end else begin
            checks++;
            if (got[0] != 130 || got[16] != 255 || got[48] != 0) begin
                failures++;
                $display("[TB] FAIL sweep_points got=%0d,%0d,%0d want=130,255,0", got[0], got[16], got[48]);
            end
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (got[k] + got[k+32] != 255) begin
                    failures++;
                    $display("[TB] FAIL sweep_mirror k=%0d got=%0d want=255", k, got[k] + got[k+32]);
                end
            end
        end
    endtask

    // Short period: 10-clock spacing, duty 5, period change at the next wrap.
    task automatic test_period_change();
        int cs_t [$];
        int hi;
        int want [6];
        hi = 0;
        want = '{1, 11, 21, 31, 41, 46};
        period = 8'd9;
        ftw = '0;
        en = 1'b1;
        do_reset();
        for (int t = 1; t <= 60; t++) begin
            tick();
            checks++;
            if (dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL period_change t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
            if (cycle_start === 1'b1) cs_t.push_back(t);
            if (t >= 21 && t <= 30 && pwm[0] === 1'b1) hi++;
            if (t == 34) period = 8'd4;
        end
        checks++;
        if (hi != 5) begin
            failures++;
            $display("[TB] FAIL period9_high got=%0d want=5", hi);
        end
        checks++;
        if (cs_t.size() < 6) begin
            failures++;
            $display("[TB] FAIL cycle_start_count got=%0d want>=6", cs_t.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cs_t[i] != want[i]) begin
                    failures++;
                    $display("[TB] FAIL cycle_start_tick i=%0d got=%0d want=%0d", i, cs_t[i], want[i]);
                end
            end
        end
    endtask

    // Twenty disabled clocks freeze the block and force pwm low.
    task automatic test_enable_pause();
        int n;
        period = 8'($urandom_range(20, 60));
        ftw = $urandom;
        en = 1'b1;
        do_reset();
        n = $urandom_range(40, 150);
        repeat (n) begin
            tick();
            checks++;
            if (dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL pause_pre t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
        end
        en = 1'b0;
        repeat (20) begin
            tick();
            checks++;
            if (pwm !== '0 || dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL pause_hold t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
        end
        en = 1'b1;
        repeat (2 * (int'(period) + 1) + 5) begin
            tick();
            checks++;
            if (dut_out !== model_vec()) begin
                failures++;
                $display("[TB] FAIL pause_resume t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
        end
    endtask

    // Random traffic, then a reset between edges and a silent first period.
    task automatic test_random_reset();
        int p;
        int n;
        for (int r = 0; r < 4; r++) begin
            p = $urandom_range(2, 30);
            period = 8'(p);
            ftw = $urandom;
            en = 1'b1;
            do_reset();
            n = $urandom_range(150, 400);
            repeat (n) begin
                if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) begin
                    p = $urandom_range(2, 30);
                    period = 8'(p);
                end
                tick();
                checks++;
                if (dut_out !== model_vec()) begin
                    failures++;
                    $display("[TB] FAIL random t=%0t got=%h want=%h", $time, dut_out, model_vec());
                end
            end
            #2 reset = 1'b1;
            #1;
            checks++;
            if (dut_out !== '0) begin
                failures++;
                $display("[TB] FAIL midrun_reset got=%h want=0", dut_out);
            end
            en = 1'b1;
            @(posedge clk);
            #3 reset = 1'b0;
            model_reset();
            for (int k = 0; k <= p; k++) begin
                tick();
                checks++;
                if (pwm !== '0 || dut_out !== model_vec()) begin
                    failures++;
                    $display("[TB] FAIL first_period t=%0t got=%h want=%h", $time, dut_out, model_vec());
                end
            end
        end
    endtask

`ifdef SINE_PWM_COMP_EN
    // Complementary outputs never overlap and switch with a DT-clock gap.
    task automatic test_deadtime();
        int side;
        int prev_side;
        int gap;
        prev_side = -1;
        gap = 0;
        period = 8'd19;
        ftw = {16'h0900, 16'h0700};
        en = 1'b1;
        do_reset();
        repeat (600) begin
            tick();
            checks++;
            if (dut_out !== model_vec() || (pwm & pwm_n) !== '0) begin
                failures++;
                $display("[TB] FAIL deadtime_out t=%0t got=%h want=%h", $time, dut_out, model_vec());
            end
            if (pwm[0] === 1'b1 || pwm_n[0] === 1'b1) begin
                side = (pwm[0] === 1'b1) ? 1 : 0;
                if (prev_side >= 0 && side != prev_side) begin
                    checks++;
                    if (gap != DT) begin
                        failures++;
                        $display("[TB] FAIL deadtime_gap t=%0t got=%0d want=%0d", $time, gap, DT);
                    end
                end
                prev_side = side;
                gap = 0;
            end else begin
                gap++;
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_fixed_duty();
        test_sine_sweep();
        test_period_change();
        test_enable_pause();
        test_random_reset();
`ifdef SINE_PWM_COMP_EN
        test_deadtime();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
